// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROL, ROR)
// that shifts STEP bit positions per cycle between valid/ready handshakes.
//
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   IN_VALID/IN_READY    operand handshake (A, B, MODE)
//   OUT_VALID/OUT_READY  result handshake (RESULT, FLAG_Z/N/C)
//
// Optional feature macro: FLAGS_EN (Z/N/C flag logic; flags tie to 0 if undefined)
module seq_shift_unit #(
    parameter  int Nbits = 8,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(Nbits)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [Nbits-1:0] A,
    input  logic [SHW-1:0]   B,
    input  logic [2:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [Nbits-1:0] RESULT,
    output logic             FLAG_Z,
    output logic             FLAG_N,
    output logic             FLAG_C
);

    // One extra bit so a full-width STEP is representable.
    localparam int CW = SHW + 1;

    localparam logic [2:0] M_SLL = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SRA = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [Nbits-1:0] r_work;
    logic [Nbits-1:0] r_result;
    logic [SHW-1:0]   r_rem;
    logic [2:0]       r_mode;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CW-1:0]    w_s;
    logic [CW-1:0]    w_inv;
    logic [SHW-1:0]   w_rem_next;
    logic [Nbits-1:0] w_next;
    logic             w_reserved;
    logic             w_zero_op;
    logic             w_acc_done;
    logic             w_shift_done;

    // Step size this cycle: min(STEP, remaining).
    always_comb begin
        w_s = {1'b0, r_rem};
        if ({1'b0, r_rem} >= CW'(STEP)) begin
            w_s = CW'(STEP);
        end
    end

    assign w_inv      = CW'(Nbits) - w_s;
    assign w_rem_next = r_rem - w_s[SHW-1:0];

    always_comb begin
        w_next = r_work;
        unique case (r_mode)
            M_SLL:   w_next = r_work << w_s;
            M_SRL:   w_next = r_work >> w_s;
            // Arithmetic shift keeps the MSB, so it always equals latched A[Nbits-1].
            M_SRA:   w_next = $unsigned($signed(r_work) >>> w_s);
            M_ROL:   w_next = (r_work << w_s) | (r_work >> w_inv);
            M_ROR:   w_next = (r_work >> w_s) | (r_work << w_inv);
            default: w_next = r_work;
        endcase
    end

    // Reserved modes behave as a zero-length shift.
    assign w_reserved   = (MODE > M_ROR);
    assign w_zero_op    = (B == '0) || w_reserved;
    assign w_acc_done   = (r_state == S_IDLE) && IN_VALID && w_zero_op;
    assign w_shift_done = (r_state == S_SHIFT) && (w_rem_next == '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_result    <= '0;
            r_rem       <= '0;
            r_mode      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_work     <= A;
                        r_rem      <= B;
                        r_mode     <= MODE;
                        r_in_ready <= 1'b0;
                        if (w_zero_op) begin
                            r_result    <= A;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_next;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_result    <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign RESULT    = r_result;

`ifdef FLAGS_EN
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic [Nbits-1:0] w_hi_out;
    logic [Nbits-1:0] w_lo_out;
    logic [CW-1:0]    w_sm1;
    logic             w_cout;

    // Last bit leaving the word this step: work[Nbits-s] for left,
    // work[s-1] for right. Over the whole op this is A[Nbits-B] / A[B-1].
    assign w_sm1    = w_s - CW'(1);
    assign w_hi_out = r_work >> w_inv;
    assign w_lo_out = r_work >> w_sm1;
    assign w_cout   = ((r_mode == M_SLL) || (r_mode == M_ROL)) ?
                      w_hi_out[0] : w_lo_out[0];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_c <= 1'b0;
        end else if (w_acc_done) begin
            r_z <= (A == '0);
            r_n <= A[Nbits-1];
            r_c <= 1'b0;
        end else if (w_shift_done) begin
            r_z <= (w_next == '0);
            r_n <= w_next[Nbits-1];
            r_c <= w_cout;
        end
    end

    assign FLAG_Z = r_z;
    assign FLAG_N = r_n;
    assign FLAG_C = r_c;
`else
    logic w_unused;
    assign w_unused = w_acc_done ^ w_shift_done;
    assign FLAG_Z   = 1'b0;
    assign FLAG_N   = 1'b0;
    assign FLAG_C   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed table, corner sequences and random ops
// for seq_shift_unit at Nbits=8 with STEP=1 (dut0) and STEP=4 (dut1).
module tb_seq_shift_unit;

    logic       clk;
    logic       rst_n     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a         [2];
    logic [2:0] b         [2];
    logic [2:0] mode      [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] result    [2];
    logic       fz        [2];
    logic       fn        [2];
    logic       fc        [2];

    int tests  = 0;
    int failed = 0;

    seq_shift_unit #(.Nbits(8), .STEP(1)) dut0 (
        .CLK(clk), .RST_N(rst_n[0]),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .A(a[0]), .B(b[0]), .MODE(mode[0]),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .RESULT(result[0]),
        .FLAG_Z(fz[0]), .FLAG_N(fn[0]), .FLAG_C(fc[0])
    );

    seq_shift_unit #(.Nbits(8), .STEP(4)) dut1 (
        .CLK(clk), .RST_N(rst_n[1]),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .A(a[1]), .B(b[1]), .MODE(mode[1]),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .RESULT(result[1]),
        .FLAG_Z(fz[1]), .FLAG_N(fn[1]), .FLAG_C(fc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [2:0] b;
        logic [2:0] mode;
        logic [7:0] res;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_flags(input logic [7:0] r,
                                             input logic c);
`ifdef FLAGS_EN
        return {r == 8'h00, r[7], c};
`else
        return 3'b000 & {r[0], r[0], c};
`endif
    endfunction

    // Reference: result bit i is picked straight from the shift/rotate rules.
    function automatic void model(input int step, input logic [7:0] av,
                                  input int bv, input int mv,
                                  output logic [7:0] r, output logic c,
                                  output int lat);
        r = av;
        c = 1'b0;
        lat = 1;
        if (bv == 0 || mv > 4) return;
        for (int i = 0; i < 8; i++) begin
            case (mv)
                0: r[i] = (i >= bv) ? av[i-bv] : 1'b0;
                1: r[i] = (i + bv < 8) ? av[i+bv] : 1'b0;
                2: r[i] = (i + bv < 8) ? av[i+bv] : av[7];
                3: r[i] = av[(i - bv + 8) % 8];
                default: r[i] = av[(i + bv) % 8];
            endcase
        end
        c = (mv == 0 || mv == 3) ? av[8-bv] : av[bv-1];
        lat = 1 + (bv + step - 1) / step;
    endfunction

    task automatic do_op(input int sel, input logic [7:0] av,
                         input logic [2:0] bv, input logic [2:0] mv,
                         input int hold, output logic [7:0] r,
                         output logic [2:0] f, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready[sel] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", {31'd0, in_ready[sel]}, 32'd1);
        in_valid[sel] = 1'b1;
        a[sel] = av;
        b[sel] = bv;
        mode[sel] = mv;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        lat = 1;
        while (!out_valid[sel] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result[sel];
        f = {fz[sel], fn[sel], fc[sel]};
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] er;
        logic [2:0] f;
        logic       ec;
        int         lat;
        int         elat;

        vec[0] = '{0, 8'hB4, 3'd3, 3'd1, 8'h16, 1'b1, 4};
        vec[1] = '{0, 8'h96, 3'd2, 3'd2, 8'hE5, 1'b1, 3};
        vec[2] = '{0, 8'h81, 3'd1, 3'd3, 8'h03, 1'b1, 2};
        vec[3] = '{1, 8'h01, 3'd7, 3'd0, 8'h80, 1'b0, 3};
        vec[4] = '{1, 8'h5A, 3'd0, 3'd0, 8'h5A, 1'b0, 1};
        vec[5] = '{0, 8'h0F, 3'd6, 3'd4, 8'h3C, 1'b0, 7};
        vec[6] = '{0, 8'hC3, 3'd4, 3'd5, 8'hC3, 1'b0, 1};
        vec[7] = '{1, 8'h0F, 3'd6, 3'd4, 8'h3C, 1'b0, 3};
        vec[8] = '{1, 8'h80, 3'd7, 3'd2, 8'hFF, 1'b0, 3};

        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            in_valid[s] = 1'b0;
            out_ready[s] = 1'b0;
            a[s] = 8'h00;
            b[s] = 3'd0;
            mode[s] = 3'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", {31'd0, in_ready[s]}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid[s]}, 32'd0);
            chk("rst_result", {24'd0, result[s]}, 32'd0);
            chk("rst_flags", {29'd0, fz[s], fn[s], fc[s]}, 32'd0);
            rst_n[s] = 1'b1;
        end

        for (int i = 0; i < 9; i++) begin
            do_op(vec[i].sel, vec[i].a, vec[i].b, vec[i].mode, 0, r, f, lat);
            chk($sformatf("vec%0d_result", i), {24'd0, r}, {24'd0, vec[i].res});
            chk($sformatf("vec%0d_flags", i), {29'd0, f},
                {29'd0, exp_flags(vec[i].res, vec[i].c)});
            chk($sformatf("vec%0d_latency", i), lat, vec[i].lat);
        end

        // Backpressure in DONE with ignored IN_VALID pulses.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0] = 8'hB4;
        b[0] = 3'd3;
        mode[0] = 3'd1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = k[0];
            a[0] = 8'hFF;
            b[0] = 3'd1;
            mode[0] = 3'd0;
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
            chk("bp_result", {24'd0, result[0]}, 32'h16);
            chk("bp_flags", {29'd0, fz[0], fn[0], fc[0]},
                {29'd0, exp_flags(8'h16, 1'b1)});
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("idle_result_kept", {24'd0, result[0]}, 32'h16);

        // Reset in the middle of a shift.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0] = 8'h0F;
        b[0] = 3'd6;
        mode[0] = 3'd4;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        chk("midrst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("midrst_result", {24'd0, result[0]}, 32'd0);
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("midrst_no_pulse", {31'd0, out_valid[0]}, 32'd0);
        end
        do_op(0, 8'h0F, 3'd6, 3'd4, 0, r, f, lat);
        chk("postrst_result", {24'd0, r}, 32'h3C);
        chk("postrst_latency", lat, 7);

        // Random operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            int         sel;
            logic [7:0] av;
            int         bv;
            int         mv;
            sel = int'($urandom_range(0, 1));
            av = 8'($urandom);
            bv = int'($urandom_range(0, 7));
            mv = int'($urandom_range(0, 7));
            model(sel == 0 ? 1 : 4, av, bv, mv, er, ec, elat);
            do_op(sel, av, 3'(bv), 3'(mv), int'($urandom_range(0, 3)),
                  r, f, lat);
            chk($sformatf("rnd%0d_result", n), {24'd0, r}, {24'd0, er});
            chk($sformatf("rnd%0d_flags", n), {29'd0, f},
                {29'd0, exp_flags(er, ec)});
            chk($sformatf("rnd%0d_latency", n), lat, elat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
